// File: rtl/sfq_arb_pkg.sv
// Shared types, default parameters and the round-robin search helper.
package sfq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int unsigned NUM_REQ_DEF     = 4;
  localparam int unsigned CNT_W_DEF       = 3;
  localparam int unsigned GAP_CYCLES_DEF  = 5;
  localparam int unsigned ACK_TIMEOUT_DEF = 8;
  localparam int unsigned MAX_REQ         = 8;

  // Returns {found, index}: first set bit of nz at or after ptr, wrapping within n.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] nz,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (!res[3] && (k < n)) begin
        idx = 3'((32'(ptr) + k) % n);
        if (nz[idx]) res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sfq_pulse_counter.sv
// Toggle-edge detector feeding a saturating pending counter with sticky overflow.
module sfq_pulse_counter
  import sfq_arb_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_tgl,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic prev;
  logic ev;

  assign ev = req_tgl ^ prev;

  // Count events up, grants down; a simultaneous event and grant cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      prev <= req_tgl;
      if (ev && !dec) begin
        if (count == CNT_MAX) overflow <= 1'b1;
        else                  count    <= count + CNT_W'(1);
      end else if (dec && !ev) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sfq_pulse_arbiter.sv
// Round-robin scheduler sharing one pulse splitter between toggle-encoded requesters.
module sfq_pulse_arbiter
  import sfq_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_tgl,
  output logic                       issue_tgl,
  input  logic                       ack1_tgl,
  input  logic                       ack2_tgl,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         overflow,
  output logic                       timeout_err,
  output logic                       spurious_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  state_t state, state_n;

  logic [CNT_W-1:0]   count [NUM_REQ];
  logic [NUM_REQ-1:0] dec;
  logic [MAX_REQ-1:0] nz;
  logic [3:0]         pick;

  logic [ID_W-1:0]  winner, winner_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             seen1, seen1_n, seen2, seen2_n;
  logic             prev_a1, prev_a2, a1, a2, both;
  logic             issue_n, grant_valid_n, busy_n, timeout_n, spurious_n;
  logic [ID_W-1:0]  grant_id_n;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    sfq_pulse_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_tgl  (req_tgl[i]),
      .dec      (dec[i]),
      .count    (count[i]),
      .overflow (overflow[i])
    );
  end

  assign a1   = ack1_tgl ^ prev_a1;
  assign a2   = ack2_tgl ^ prev_a2;
  assign both = (seen1 | a1) & (seen2 | a2);

  // Nonzero map of pending counters and the round-robin winner from ptr.
  always_comb begin
    nz = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) nz[i] = (count[i] != '0);
    pick = rr_pick(nz, 3'(ptr), NUM_REQ);
  end

  // Decrement the latched winner's counter in the ISSUE cycle.
  always_comb begin
    dec = '0;
    for (int i = 0; i < int'(NUM_REQ); i++)
      if ((state == ISSUE) && (winner == ID_W'(i))) dec[i] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (pick[3]) state_n = ISSUE;
      ISSUE:    state_n = WAIT_ACK;
      WAIT_ACK: if (both || (timer == TMR_W'(ACK_TIMEOUT - 1))) state_n = GAP;
      GAP:      if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs.
  always_comb begin
    winner_n      = winner;
    ptr_n         = ptr;
    timer_n       = timer;
    gap_cnt_n     = gap_cnt;
    seen1_n       = seen1;
    seen2_n       = seen2;
    issue_n       = issue_tgl;
    grant_valid_n = 1'b0;
    grant_id_n    = grant_id;
    timeout_n     = timeout_err;
    spurious_n    = spurious_err;
    busy_n        = (state_n != IDLE);
    // Any ack edge outside WAIT_ACK is unexpected.
    if ((state != WAIT_ACK) && (a1 || a2)) spurious_n = 1'b1;
    unique case (state)
      IDLE: begin
        if (pick[3]) winner_n = ID_W'(pick[2:0]);
      end
      ISSUE: begin
        issue_n       = ~issue_tgl;
        grant_valid_n = 1'b1;
        grant_id_n    = winner;
        ptr_n         = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        seen1_n       = 1'b0;
        seen2_n       = 1'b0;
        timer_n       = '0;
      end
      WAIT_ACK: begin
        seen1_n   = seen1 | a1;
        seen2_n   = seen2 | a2;
        timer_n   = timer + TMR_W'(1);
        gap_cnt_n = '0;
        if ((a1 && seen1) || (a2 && seen2)) spurious_n = 1'b1;
        if (!both && (timer == TMR_W'(ACK_TIMEOUT - 1))) timeout_n = 1'b1;
      end
      GAP: begin
        gap_cnt_n = gap_cnt + GAP_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner       <= '0;
      ptr          <= '0;
      timer        <= '0;
      gap_cnt      <= '0;
      seen1        <= 1'b0;
      seen2        <= 1'b0;
      prev_a1      <= 1'b0;
      prev_a2      <= 1'b0;
      issue_tgl    <= 1'b0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
    end else begin
      winner       <= winner_n;
      ptr          <= ptr_n;
      timer        <= timer_n;
      gap_cnt      <= gap_cnt_n;
      seen1        <= seen1_n;
      seen2        <= seen2_n;
      prev_a1      <= ack1_tgl;
      prev_a2      <= ack2_tgl;
      issue_tgl    <= issue_n;
      grant_valid  <= grant_valid_n;
      grant_id     <= grant_id_n;
      busy         <= busy_n;
      timeout_err  <= timeout_n;
      spurious_err <= spurious_n;
    end
  end

endmodule

// File: tb/tb_sfq_pulse_arbiter.sv
// Directed bench for sfq_pulse_arbiter: vector table plus hand-written corner sequences.
module tb_sfq_pulse_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_tgl;
  logic       issue_tgl;
  logic       ack1_tgl, ack2_tgl;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] overflow;
  logic       timeout_err, spurious_err;

  // Ack sources: automatic splitter model (m*) xor manual pokes (x*).
  logic m1, m2, x1, x2;
  logic last_issue;
  int   acnt;
  logic ack_en, en1, en2;
  int   ack_lat;

  int   cyc = 0;
  logic [1:0] gq_id[$];
  int         gq_cyc[$];

  int n_tests = 0;
  int n_fail  = 0;

  assign ack1_tgl = m1 ^ x1;
  assign ack2_tgl = m2 ^ x2;

  sfq_pulse_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_tgl      (req_tgl),
    .issue_tgl    (issue_tgl),
    .ack1_tgl     (ack1_tgl),
    .ack2_tgl     (ack2_tgl),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .busy         (busy),
    .overflow     (overflow),
    .timeout_err  (timeout_err),
    .spurious_err (spurious_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every grant with the cycle it was seen.
  always @(negedge clk) begin
    if (rst_n && grant_valid) begin
      gq_id.push_back(grant_id);
      gq_cyc.push_back(cyc);
    end
  end

  // Splitter model: both outputs toggle ack_lat cycles after each issue toggle.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_issue <= 1'b0;
      acnt       <= 0;
      m1         <= 1'b0;
      m2         <= 1'b0;
    end else if (issue_tgl !== last_issue) begin
      last_issue <= issue_tgl;
      acnt       <= ack_lat - 1;
    end else if (acnt != 0) begin
      acnt <= acnt - 1;
      if (acnt == 1 && ack_en) begin
        if (en1) m1 <= ~m1;
        if (en2) m2 <= ~m2;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req_tgl = 4'b0;
    x1 = 1'b0; x2 = 1'b0;
    ack_en = 1'b1; en1 = 1'b1; en2 = 1'b1;
    ack_lat = 2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gq_id.delete();
    gq_cyc.delete();
  endtask

  task automatic tog(input logic [3:0] m);
    req_tgl = req_tgl ^ m;
    @(negedge clk);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int b;
    b = budget;
    while (gq_id.size() < n && b > 0) begin
      @(negedge clk); #1;
      b--;
    end
    if (gq_id.size() < n) check("grant_wait_expired", gq_id.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = budget;
    while (busy && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (busy) check("idle_wait_expired", 32'(busy), 0);
  endtask

  typedef struct {
    logic [3:0] mask;
    int         n;
    logic [7:0] ids;   // {id3,id2,id1,id0}
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n0, t;
    logic [7:0] idv;

    vecs[0] = '{mask: 4'b1011, n: 3, ids: {2'd0, 2'd3, 2'd1, 2'd0}};
    vecs[1] = '{mask: 4'b1111, n: 4, ids: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[2] = '{mask: 4'b1000, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[3] = '{mask: 4'b0110, n: 2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};
    vecs[4] = '{mask: 4'b0101, n: 2, ids: {2'd0, 2'd0, 2'd2, 2'd0}};

    // Reset values.
    do_reset();
    check("rst_issue", 32'(issue_tgl), 0);
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_errs", 32'({timeout_err, spurious_err}), 0);

    // Single request: exact latency, one-cycle strobe, GAP length.
    n0 = cyc;
    tog(4'b0100);
    repeat (3) @(negedge clk);
    check("t1_grant_count", gq_id.size(), 1);
    if (gq_id.size() > 0) begin
      check("t1_grant_id", 32'(gq_id[0]), 2);
      check("t1_grant_latency", gq_cyc[0] - n0, 3);
    end
    check("t1_issue_tgl", 32'(issue_tgl), 1);
    @(negedge clk);
    check("t1_strobe_one_cycle", 32'(grant_valid), 0);
    check("t1_grant_id_hold", 32'(grant_id), 2);
    repeat (4) @(negedge clk);
    check("t1_busy_last_gap", 32'(busy), 1);
    @(negedge clk);
    check("t1_busy_fall", 32'(busy), 0);
    check("t1_errs", 32'({timeout_err, spurious_err}), 0);

    // Table: simultaneous requests served round-robin from ptr 0.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      tog(vecs[v].mask);
      wait_grants(vecs[v].n, 120);
      wait_idle(40);
      check($sformatf("v%0d_grant_count", v), gq_id.size(), vecs[v].n);
      idv = vecs[v].ids;
      for (int j = 0; j < vecs[v].n && j < gq_id.size(); j++) begin
        check($sformatf("v%0d_id%0d", v, j), 32'(gq_id[j]), 32'(idv[2*j +: 2]));
        if (j > 0) check($sformatf("v%0d_spacing%0d", v, j), gq_cyc[j] - gq_cyc[j-1], 9);
      end
      check($sformatf("v%0d_issue_level", v), 32'(issue_tgl), 32'(vecs[v].n % 2));
      check($sformatf("v%0d_errs", v), 32'({timeout_err, spurious_err}), 0);
    end

    // Pointer advances past the last winner.
    do_reset();
    tog(4'b0100);
    wait_grants(1, 20);
    wait_idle(40);
    tog(4'b1001);
    wait_grants(3, 60);
    if (gq_id.size() == 3) begin
      check("rr_after2_first", 32'(gq_id[1]), 3);
      check("rr_after2_second", 32'(gq_id[2]), 0);
    end

    // Saturation: 9 toggles on req1 with the ack model stalled.
    do_reset();
    ack_en = 1'b0;
    for (int k = 0; k < 9; k++) tog(4'b0010);
    ack_en = 1'b1;
    check("t3_overflow", 32'(overflow), 32'h2);
    wait_grants(8, 300);
    repeat (40) @(negedge clk);
    check("t3_grant_total", gq_id.size(), 8);
    for (int j = 0; j < gq_id.size(); j++) check($sformatf("t3_id%0d", j), 32'(gq_id[j]), 1);
    check("t3_inflight_timeout", 32'(timeout_err), 1);
    check("t3_no_spurious", 32'(spurious_err), 0);

    // Timeout: only ack1 returns on the first issue.
    do_reset();
    en2 = 1'b0;
    tog(4'b0011);
    wait_grants(1, 20);
    repeat (7) @(negedge clk);
    check("t4_no_timeout_yet", 32'(timeout_err), 0);
    @(negedge clk);
    check("t4_timeout_set", 32'(timeout_err), 1);
    check("t4_busy_gap", 32'(busy), 1);
    en2 = 1'b1;
    wait_grants(2, 40);
    if (gq_id.size() >= 2) check("t4_next_served", 32'(gq_id[1]), 1);
    wait_idle(40);
    check("t4_no_spurious", 32'(spurious_err), 0);

    // Spurious: ack2 edge while idle.
    do_reset();
    x2 = ~x2;
    repeat (2) @(negedge clk);
    check("t5_spurious_idle", 32'(spurious_err), 1);
    check("t5_idle_quiet", 32'({busy, issue_tgl, timeout_err}), 0);
    check("t5_no_grant", gq_id.size(), 0);

    // Spurious: two ack1 edges in one WAIT_ACK.
    do_reset();
    ack_en = 1'b0;
    tog(4'b0001);
    wait_grants(1, 20);
    x1 = ~x1;
    @(negedge clk);
    check("t5_first_edge_ok", 32'(spurious_err), 0);
    x1 = ~x1;
    @(negedge clk);
    check("t5_double_edge", 32'(spurious_err), 1);

    // Async reset mid-WAIT_ACK with counts pending.
    do_reset();
    ack_en = 1'b0;
    tog(4'b0010);
    tog(4'b0011);
    wait_grants(1, 20);
    repeat (2) @(negedge clk);
    check("t6_busy_before", 32'(busy), 1);
    check("t6_grant_id_before", 32'(grant_id), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_outputs", 32'({issue_tgl, grant_valid, grant_id, busy}), 0);
    check("t6_async_flags", 32'({overflow, timeout_err, spurious_err}), 0);
    req_tgl = 4'b0; x1 = 1'b0; x2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    gq_id.delete();
    gq_cyc.delete();
    repeat (20) @(negedge clk);
    check("t6_counts_cleared", gq_id.size(), 0);
    check("t6_idle", 32'({busy, spurious_err}), 0);
    x1 = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_late_ack_spurious", 32'(spurious_err), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sfq_pulse_arbiter.md
Name: sfq_pulse_arbiter

Overview:
- Clocked scheduler that shares one pulse-splitter cell between NUM_REQ requesters.
- Pulses are toggle-encoded, as in the splitter models: every edge, rising or falling, is one pulse.
- The block queues request pulses, issues them to the splitter input one at a time in round-robin order, and checks that both splitter outputs respond.
- It enforces a minimum recovery gap between issued pulses, and is the sequencing wrapper around splitter instances in the test harness.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 3, width of each per-requester pending counter; saturates at 2^CNT_W-1.
- GAP_CYCLES, 5, idle clock cycles enforced after each acknowledged or timed-out issue (>=1).
- ACK_TIMEOUT, 8, cycles allowed in WAIT_ACK for both splitter outputs to toggle (>=2).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_tgl  in  NUM_REQ  toggle-encoded request pulses; clk-synchronous, no synchronisers.
- issue_tgl  out  1  drives splitter input; toggles once per issued pulse.
- ack1_tgl  in  1  from splitter out1.
- ack2_tgl  in  1  from splitter out2.
- grant_valid  out  1  one-cycle strobe in the cycle issue_tgl toggles.
- grant_id  out  $clog2(NUM_REQ)  requester served; valid with grant_valid, otherwise holds its last value.
- busy  out  1  high in every state except IDLE.
- overflow  out  NUM_REQ  sticky per requester; set when a request event arrives while that counter is saturated.
- timeout_err  out  1  sticky; set on ACK_TIMEOUT expiry.
- spurious_err  out  1  sticky; set on any ack edge outside WAIT_ACK, or a second edge on the same ack within one WAIT_ACK.

Behaviour:
- Reset (async assert, sync release):
  - issue_tgl=0, grant_valid=0, grant_id=0, busy=0, all sticky errors 0.
  - Counters 0, edge-detect registers 0, round-robin pointer 0, FSM=IDLE.
  - Reset mid-transaction abandons the transaction; acks arriving after release are flagged spurious.
- Edge detect:
  - ev[i] = req_tgl[i] XOR prev[i]; prev registered every cycle.
  - Same for acks: a1 = ack1_tgl XOR prev_a1, a2 likewise.
- Pending counter i:
  - +1 on ev[i]; -1 when granted.
  - Both in the same cycle: unchanged.
  - ev[i] while saturated with no grant: hold the value and set overflow[i]; the event is dropped.
- Round-robin selection:
  - Search starts at ptr, wrapping; the first requester with a nonzero count wins.
  - On grant, ptr = winner+1 mod NUM_REQ.
- FSM:
  - IDLE: if any count>0, latch winner, go ISSUE.
  - ISSUE (1 cycle): toggle issue_tgl, grant_valid=1, grant_id=winner, decrement winner count, clear ack-seen flags, timer=0, go WAIT_ACK.
  - WAIT_ACK:
    - Set seen1/seen2 on a1/a2; both may arrive in the same cycle.
    - When both are seen (counting the current cycle), go GAP.
    - Otherwise, when timer reaches ACK_TIMEOUT-1, set timeout_err and go GAP. The transaction is dropped, not retried.
    - timer increments each cycle.
  - GAP: count GAP_CYCLES cycles, then IDLE.
- Latency:
  - A req edge sampled at edge k increments the count at k.
  - If idle, IDLE->ISSUE at k+1, and issue_tgl toggles at k+2.
  - Back-to-back throughput is one pulse per 1+1+ack_latency+GAP_CYCLES cycles minimum.
- Requests keep accumulating in every state.

Decomposition:
- Package sfq_arb_pkg:
  - FSM state enum {IDLE, ISSUE, WAIT_ACK, GAP}.
  - Default parameter constants.
  - Helper function for round-robin search.
- One sub-module, sfq_pulse_counter: edge detect plus a saturating up/down counter with overflow flag, instantiated NUM_REQ times.
- Ack edge detection stays inline in the top level.

Test Plan:
1. Reset, then a single req_tgl[2] 0->1 at edge 10 -> issue_tgl toggles at edge 12, grant_id=2 and grant_valid for 1 cycle. Both acks toggle at edge 14 -> busy stays high through GAP and falls 5 cycles later; no errors.
2. Requesters 0, 1 and 3 each toggle once in the same cycle, with the ack model returning both acks 2 cycles after issue -> grants in order 0, 1, 3. Each issue_tgl toggle is spaced 1+2+5+1 cycles apart; issue_tgl returns to 1 after 3 toggles.
3. req_tgl[1] toggles 9 times while the ack model is stalled, CNT_W=3 -> count saturates at 7 and overflow[1]=1. After the stall is released, exactly 8 grants to requester 1 are issued (1 in flight plus 7 queued).
4. Only ack1 returns -> after 8 WAIT_ACK cycles timeout_err=1 and the FSM goes GAP then IDLE. The next queued request is still served normally.
5. ack2 toggles while IDLE -> spurious_err=1 with no other state change. In a separate run, ack1 toggles twice in one WAIT_ACK -> spurious_err=1.
6. rst_n is asserted asynchronously mid-WAIT_ACK with counts nonzero -> all outputs and counters are 0 immediately. A late ack after release sets spurious_err.
